// File: rtl/barrett_reduce_pipe.sv
// Pipelined signed Barrett reducer, LANES coefficients per beat with a common handshake and tag passthrough.
// Latency: 3 cycles from acceptance to out_valid, or 4 when BARRETT_CANON_EN adds the [0,Q) correction stage.
// Backpressure: a stalled output freezes the whole pipe (in_ready = !last_valid || out_ready); bubbles are not squeezed out.
module barrett_reduce_pipe #(
  parameter int DW    = 16,
  parameter int Q     = 3329,
  parameter int V     = 20159,
  parameter int SHIFT = 26,
  parameter int LANES = 1,
  parameter int TAGW  = 8
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [TAGW-1:0]       out_tag
);

  // Product width covers any DW-bit input times V; t needs only the bits above SHIFT plus a sign bit.
  localparam int PW = DW + $clog2(V) + 1;
  localparam int TW = PW - SHIFT + 1;

  localparam logic signed [PW-1:0] VC = PW'(V);
  localparam logic signed [PW-1:0] RC = PW'(2 ** (SHIFT - 1));
  localparam logic signed [DW-1:0] QD = DW'(Q);

  // S1 keeps the rounded product already shifted down: its low SHIFT bits never reach t.
  logic                   s1_valid;
  logic [LANES*TW-1:0]    s1_t;
  logic [LANES*DW-1:0]    s1_a;
  logic [TAGW-1:0]        s1_tag;

  // S2 keeps only the low DW bits of t*Q, which is all the truncated subtraction needs.
  logic                   s2_valid;
  logic [LANES*DW-1:0]    s2_tq;
  logic [LANES*DW-1:0]    s2_a;
  logic [TAGW-1:0]        s2_tag;

  logic                   s3_valid;
  logic [LANES*DW-1:0]    s3_r;
  logic [TAGW-1:0]        s3_tag;

  logic [LANES*TW-1:0]    t_nxt;
  logic [LANES*DW-1:0]    tq_nxt;
  logic [LANES*DW-1:0]    r_nxt;
  logic                   last_valid;
  logic                   en;

  // Per-lane datapath feeding each pipeline register
  always_comb begin
    t_nxt  = '0;
    tq_nxt = '0;
    r_nxt  = '0;
    for (int i = 0; i < LANES; i++) begin
      t_nxt[i*TW +: TW] = TW'(($signed({{(PW-DW){in_data[i*DW+DW-1]}}, in_data[i*DW +: DW]}) * VC + RC) >>> SHIFT);
      tq_nxt[i*DW +: DW] = $signed({{(DW-TW){s1_t[i*TW+TW-1]}}, s1_t[i*TW +: TW]}) * QD;
      r_nxt[i*DW +: DW]  = s2_a[i*DW +: DW] - s2_tq[i*DW +: DW];
    end
  end

  // Single advance enable: every stage moves together unless the output beat is stuck
  assign en       = !last_valid || out_ready;
  assign in_ready = en;

  // Stages S1..S3: valid bits and data advance together on en
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
      s1_a     <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_tq    <= '0;
      s2_a     <= '0;
      s2_tag   <= '0;
      s3_valid <= 1'b0;
      s3_r     <= '0;
      s3_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_t     <= t_nxt;
      s1_a     <= in_data;
      s1_tag   <= in_tag;
      s2_valid <= s1_valid;
      s2_tq    <= tq_nxt;
      s2_a     <= s1_a;
      s2_tag   <= s1_tag;
      s3_valid <= s2_valid;
      s3_r     <= r_nxt;
      s3_tag   <= s2_tag;
    end
  end

`ifdef BARRETT_CANON_EN
  logic                   s4_valid;
  logic [LANES*DW-1:0]    s4_r;
  logic [TAGW-1:0]        s4_tag;
  logic [LANES*DW-1:0]    canon_nxt;

  // Fold the centred value into [0,Q) by adding Q to negative lanes
  always_comb begin
    canon_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      canon_nxt[i*DW +: DW] = s3_r[i*DW+DW-1] ? s3_r[i*DW +: DW] + QD : s3_r[i*DW +: DW];
    end
  end

  // Stage S4: canonical result register
  always_ff @(posedge clk) begin
    if (srst) begin
      s4_valid <= 1'b0;
      s4_r     <= '0;
      s4_tag   <= '0;
    end else if (en) begin
      s4_valid <= s3_valid;
      s4_r     <= canon_nxt;
      s4_tag   <= s3_tag;
    end
  end

  assign last_valid = s4_valid;
  assign out_valid  = s4_valid;
  assign out_data   = s4_r;
  assign out_tag    = s4_tag;
`else
  assign last_valid = s3_valid;
  assign out_valid  = s3_valid;
  assign out_data   = s3_r;
  assign out_tag    = s3_tag;
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Bench for barrett_reduce_pipe with four lanes: directed vectors, random stream, backpressure and mid-run reset.
// Inputs change 1 time unit after the rising edge; every sample and handshake decision happens on the falling edge.
// Expected beats queue in a scoreboard when accepted and are matched in order against the output handshakes.
module tb_barrett_reduce_pipe;

`ifdef BARRETT_CANON_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        srst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_tag;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stalls = 0;
  bit lat_chk = 1'b1;

  logic [63:0] exp_q[$];
  logic [7:0]  tag_q[$];
  int          cyc_q[$];

  barrett_reduce_pipe #(
    .DW(16), .Q(3329), .V(20159), .SHIFT(26), .LANES(4), .TAGW(8)
  ) dut (
    .clk(clk),
    .srst(srst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference reduction of one coefficient
  function automatic logic [15:0] gold(input logic [15:0] a);
    longint aa;
    longint t;
    longint r;
    aa = longint'($signed(a));
    t  = (aa * 20159 + 33554432) >>> 26;
    r  = aa - t * 3329;
`ifdef BARRETT_CANON_EN
    if (r < 0) r = r + 3329;
`endif
    return 16'(r);
  endfunction

  function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  // Present one beat and hold it until the falling edge shows in_ready; in_valid stays high afterwards
  task automatic send(input logic [63:0] d, input logic [7:0] tg, input logic [63:0] e);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = tg;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!in_ready) begin
      check("send_timeout", {63'd0, in_ready}, 64'd1);
    end else begin
      exp_q.push_back(e);
      tag_q.push_back(tg);
      cyc_q.push_back(lat_chk ? cyc : -1);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [7:0] tg);
    logic [63:0] d;
    logic [63:0] e;
    for (int l = 0; l < 4; l++) begin
      d[l*16 +: 16] = 16'($urandom);
      e[l*16 +: 16] = gold(d[l*16 +: 16]);
    end
    send(d, tg, e);
  endtask

  // Single beat, pipe otherwise empty, then let it drain
  task automatic dir(input logic [63:0] d, input logic [7:0] tg, input logic [63:0] e);
    send(d, tg, e);
    idle();
    repeat (LAT + 2) @(negedge clk);
  endtask

  // Output scoreboard: every output handshake must match the oldest accepted beat
  always @(negedge clk) begin
    logic [63:0] e;
    logic [7:0]  t;
    int          c;
    if (!srst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        c = cyc_q.pop_front();
        check("out_data", out_data, e);
        check("out_tag", {56'd0, out_tag}, {56'd0, t});
        if (c >= 0) check("latency", 64'(cyc - c), 64'(LAT));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    srst      = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", {56'd0, out_tag}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed single beats on lane 0, other lanes zero
    dir(pack4(3329, 0, 0, 0), 8'h01, pack4(0, 0, 0, 0));
    dir(pack4(1664, 0, 0, 0), 8'h02, pack4(1664, 0, 0, 0));
`ifdef BARRETT_CANON_EN
    dir(pack4(1665, 0, 0, 0), 8'h03, pack4(1665, 0, 0, 0));
    dir(pack4(-32768, 0, 0, 0), 8'h04, pack4(522, 0, 0, 0));
    dir(pack4(32767, 0, 0, 0), 8'h05, pack4(2806, 0, 0, 0));
    dir(pack4(0, 0, 0, 0), 8'h06, pack4(0, 0, 0, 0));
    dir(pack4(3329, -1, 6658, 1665), 8'h07, pack4(0, 3328, 0, 1665));
`else
    dir(pack4(1665, 0, 0, 0), 8'h03, pack4(-1664, 0, 0, 0));
    dir(pack4(-32768, 0, 0, 0), 8'h04, pack4(522, 0, 0, 0));
    dir(pack4(32767, 0, 0, 0), 8'h05, pack4(-523, 0, 0, 0));
    dir(pack4(0, 0, 0, 0), 8'h06, pack4(0, 0, 0, 0));
    dir(pack4(3329, -1, 6658, 1665), 8'h07, pack4(0, -1, 0, -1664));
`endif
    // Extremes spread across lanes to exercise each lane's datapath
    dir(pack4(32767, -32768, 1664, -1665), 8'h08, {gold(16'hF97F), gold(16'd1664), gold(16'h8000), gold(16'h7FFF)});

    // Back-to-back random stream with the output always ready
    stalls = 0;
    for (int i = 0; i < 1000; i++) send_rand(8'(i));
    idle();
    check("stream_stalls", 64'(stalls), 64'd0);
    repeat (LAT + 2) @(negedge clk);

    // Backpressure with a full pipe: hold out_ready low for 5 cycles
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand(8'(8'h80 + i));
        idle();
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_in_ready", {63'd0, in_ready}, 64'd0);
          check("bp_out_valid", {63'd0, out_valid}, 64'd1);
          check("bp_out_data", out_data, exp_q[0]);
          check("bp_out_tag", {56'd0, out_tag}, {56'd0, tag_q[0]});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (LAT + 4) @(negedge clk);
    check("bp_drain", 64'(exp_q.size()), 64'd0);
    lat_chk = 1'b1;

    // Mid-run reset with three beats in flight; a beat offered during reset is dropped
    send(pack4(100, 200, 300, 400), 8'h11, pack4(100, 200, 300, 400));
    send(pack4(5000, 0, 0, 0), 8'h12, {48'd0, gold(16'd5000)});
    send(pack4(-5000, 0, 0, 0), 8'h13, {48'd0, gold(16'hEC78)});
    @(posedge clk);
    #1;
    srst     = 1'b1;
    in_valid = 1'b1;
    in_data  = pack4(7, 7, 7, 7);
    in_tag   = 8'h77;
    @(negedge clk);
    exp_q.delete();
    tag_q.delete();
    cyc_q.delete();
    @(posedge clk);
    #1;
    srst     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (LAT + 3) @(negedge clk);
`ifdef BARRETT_CANON_EN
    dir(pack4(1665, 3329, 0, -1), 8'h5A, pack4(1665, 0, 0, 3328));
`else
    dir(pack4(1665, 3329, 0, -1), 8'h5A, pack4(-1664, 0, 0, -1));
`endif
    repeat (5) @(negedge clk);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/barrett_reduce_pipe.md
Name: barrett_reduce_pipe

Overview:
Parametrised, pipelined signed Barrett reducer. Successor to the fixed 16-bit Kyber reducer, generalised in modulus, width and lane count, with valid/ready flow control and sideband tag passthrough. Sits between NTT butterfly/pointwise-multiply datapaths and coefficient RAMs. Produces the centred representative of a mod Q; an optional final stage gives the canonical [0,Q) value.

Parameters:
DW, 16, signed input/output coefficient width per lane
Q, 3329, modulus (odd, Q < 2^(DW-1))
V, 20159, Barrett constant = round(2^SHIFT / Q)
SHIFT, 26, Barrett shift amount
LANES, 1, independent coefficients processed in parallel (common handshake)
TAGW, 8, sideband tag width carried alongside data

Ports:
clk  in  1  system clock
srst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  LANES*DW  signed coefficients, lane i at bits [i*DW +: DW]
in_tag  in  TAGW  sideband, returned unchanged with the result
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  LANES*DW  reduced coefficients, same lane packing
out_tag  out  TAGW  tag of this result beat

Behaviour:
- One clock (clk); reset srst is synchronous and active-high. All state is updated on the rising edge of clk.
- Per lane, with a as a signed DW-bit value:
  - t = (a*V + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, floor toward -inf.
  - r = a - t*Q, truncated to DW bits.
  - Default result range: [-(Q-1)/2, (Q-1)/2].
- Internal widths:
  - product width PW = DW + clog2(V) + 1, signed; no overflow for any DW-bit input.
  - t width PW - SHIFT + 1, signed.
- Pipeline is 3 stages, latency 3 cycles from input acceptance to out_valid.
  - S1: register a*V + round constant, a, tag.
  - S2: register t*Q, a, tag.
  - S3: register r, tag.
- Each stage has a valid bit.
- Global advance enable: en = !s_last_valid || out_ready.
  - in_ready = en (combinational). A beat is accepted when in_valid && in_ready.
  - When en = 0, all stages hold their data and valid bits. Bubbles are not compressed.
- Throughput: 1 beat/cycle while out_ready stays high.
- out_data/out_tag hold stable while out_valid && !out_ready. Data and tag must not change until the beat is taken.
- Reset:
  - all valid bits go to 0; out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 during the first cycle after reset deasserts.
  - Reset mid-operation discards in-flight beats with no partial output.
  - A beat presented in the same cycle srst is high is dropped.
- Simultaneous accept and release in one cycle is allowed and is the normal case.

Optional Feature:
- Macro BARRETT_CANON_EN.
- When defined:
  - adds a stage S4 computing r + Q when r < 0, else r.
  - output range is [0, Q-1].
  - latency is 4 cycles; the en equation uses the S4 valid bit.
- When undefined: 3-stage centred output as above.

Test Plan:
- Single beat, LANES=1, in_data=3329 -> out_data=0 exactly 3 cycles after acceptance; in_data=1664 -> 1664; in_data=1665 -> -1664 (CANON: 1665).
- Extremes: in_data=-32768 -> 522; in_data=32767 -> -523 (CANON: 2806); in_data=0 -> 0.
- Streaming 1000 random beats with out_ready=1 and in_valid=1 -> one result per cycle; results match the golden model a - Q*floor((a*V+2^25)/2^26) and tags come back in order.
- Backpressure: drop out_ready low for 5 cycles with a full pipe -> in_ready=0, out_data/out_tag stable; on release, no beats lost or duplicated.
- LANES=4, Q=3329, in_data lanes {3329, -1, 6658, 1665} -> {0, -1, 0, -1664}; check lane packing.
- Assert srst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle and no stale beats later; the next accepted beat (tag 0x5A) emerges correctly with tag 0x5A.
